// File: rtl/serv_state_vec.sv
// Instruction sequencer for the serial core: FETCH -> (INIT -> WAIT) -> EXEC,
// with an optional VPU loop that repeats the execute pass once per element.
//
// state | meaning
// FETCH | waiting for the instruction bus to return an instruction
// ARM   | RF read issued, waiting for RF ready before the first pass
// INIT  | first (address/compare) pass of a two-stage instruction
// WAIT  | waiting for memory, MDU, VPU or shifter; traps skip straight on
// ARM2  | RF read issued, waiting for RF ready before an execute pass
// EXEC  | execute pass, repeated per vector element for VPU ops
module serv_state_vec #(
  parameter int XLEN     = 32,
  parameter int W        = 1,
  parameter int VLW      = 4,
  parameter int WITH_CSR = 1,
  parameter int ALIGN    = 0,
  parameter int MDU      = 0,
  parameter int VPU      = 0,
  localparam int CYC     = XLEN / W,
  localparam int CW      = $clog2(CYC)
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_ibus_ack,
  input  logic           i_rf_ready,
  input  logic           i_two_stage_op,
  input  logic           i_branch_op,
  input  logic           i_cond_branch,
  input  logic           i_bne_or_bge,
  input  logic           i_alu_cmp,
  input  logic           i_dbus_en,
  input  logic           i_mem_misalign,
  input  logic           i_ctrl_misalign,
  input  logic           i_e_op,
  input  logic           i_new_irq,
  input  logic           i_rd_op,
  input  logic           i_slt_or_branch,
  input  logic           i_shift_op,
  input  logic           i_sh_done,
  input  logic           i_dbus_ack,
  input  logic           i_mdu_op,
  input  logic           i_mdu_ready,
  input  logic           i_vpu_op,
  input  logic           i_vpu_ready,
  input  logic [VLW-1:0] i_vpu_vl,
  output logic           o_ibus_cyc,
  output logic           o_dbus_cyc,
  output logic           o_rf_rreq,
  output logic           o_rf_wreq,
  output logic           o_rf_rd_en,
  output logic           o_init,
  output logic           o_cnt_en,
  output logic [CW-1:0]  o_cnt,
  output logic           o_cnt0,
  output logic           o_cnt_done,
  output logic           o_ctrl_pc_en,
  output logic           o_ctrl_jump,
  output logic           o_ctrl_trap,
  output logic           o_mdu_valid,
  output logic           o_vpu_valid,
  output logic [VLW-1:0] o_vpu_elem,
  output logic           o_vpu_last
);

  localparam logic CSR_ON   = (WITH_CSR != 0);
  localparam logic ALIGN_ON = (ALIGN != 0);
  localparam logic MDU_ON   = (MDU != 0);
  localparam logic VPU_ON   = (VPU != 0);

  typedef enum logic [2:0] {FETCH, ARM, INIT, WAIT, ARM2, EXEC} state_t;

  state_t         state;
  logic           trap_r;
  logic           rreq_pend;
  logic           cnt_last;
  logic           vpu_act;
  logic           jump_nxt;
  logic           trap_nxt;
  logic           wreq_src;
  logic           elem_loop;
  logic [VLW-1:0] vl_m1;

  assign cnt_last  = (o_cnt == CW'(CYC - 1));
  assign vpu_act   = VPU_ON & i_vpu_op;
  assign vl_m1     = (i_vpu_vl == '0) ? '0 : i_vpu_vl - 1'b1;
  assign jump_nxt  = i_branch_op & (!i_cond_branch | (i_alu_cmp ^ i_bne_or_bge));
  assign trap_nxt  = CSR_ON & ((jump_nxt & i_ctrl_misalign & !ALIGN_ON) |
                               (i_dbus_en & i_mem_misalign));
  assign wreq_src  = i_dbus_ack | (MDU_ON & i_mdu_ready) | (VPU_ON & i_vpu_ready) |
                     i_slt_or_branch | (i_shift_op & i_sh_done);

  assign o_ibus_cyc   = (state == FETCH) & !i_rst;
  assign o_init       = (state == INIT);
  assign o_cnt_en     = (state == INIT) | (state == EXEC);
  assign o_cnt0       = o_cnt_en & (o_cnt == '0);
  assign o_cnt_done   = o_cnt_en & cnt_last;
  assign o_vpu_last   = !vpu_act | (o_vpu_elem >= vl_m1);
  assign o_ctrl_trap  = CSR_ON & (i_e_op | i_new_irq | trap_r);
  assign o_ctrl_pc_en = (state == EXEC) & (o_vpu_last | o_ctrl_trap);
  assign o_rf_rd_en   = (state == EXEC) & i_rd_op;
  assign o_dbus_cyc   = (state == WAIT) & i_dbus_en & !i_mem_misalign & !trap_r;
  assign o_mdu_valid  = (state == WAIT) & MDU_ON & i_mdu_op & !trap_r;
  assign o_vpu_valid  = (state == WAIT) & vpu_act & !trap_r;
  assign o_rf_wreq    = (state == WAIT) & !trap_r & wreq_src;
  // Second RF read is either the trap redirect from WAIT or the next element's operands.
  assign o_rf_rreq    = ((state == FETCH) & i_ibus_ack) | ((state == WAIT) & trap_r) | rreq_pend;
  assign elem_loop    = vpu_act & !o_vpu_last & !o_ctrl_trap;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= FETCH;
      o_cnt       <= '0;
      o_ctrl_jump <= 1'b0;
      o_vpu_elem  <= '0;
      trap_r      <= 1'b0;
      rreq_pend   <= 1'b0;
    end else begin
      rreq_pend <= 1'b0;
      if (o_cnt_en) o_cnt <= cnt_last ? '0 : o_cnt + 1'b1;
      case (state)
        FETCH: if (i_ibus_ack) begin
          o_vpu_elem <= '0;
          state      <= ARM;
        end
        ARM: if (i_rf_ready) state <= (i_two_stage_op & !i_new_irq) ? INIT : EXEC;
        INIT: if (cnt_last) begin
          o_ctrl_jump <= jump_nxt;
          trap_r      <= trap_nxt;
          state       <= WAIT;
        end
        WAIT: if (trap_r | wreq_src) state <= ARM2;
        ARM2: if (i_rf_ready) state <= EXEC;
        EXEC: if (cnt_last) begin
          if (elem_loop) begin
            o_vpu_elem <= o_vpu_elem + 1'b1;
            rreq_pend  <= 1'b1;
            state      <= ARM2;
          end else begin
            o_ctrl_jump <= 1'b0;
            trap_r      <= 1'b0;
            state       <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule
